// File: rtl/calculadora_datapath.sv
// calculadora_datapath: accumulator/output registers with signed add/sub ALU, sticky overflow, valid strobe and op counter.
// Optional SATURATE_EN macro clamps AcReg on overflow instead of wrapping.
module calculadora_datapath #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     entrada,
    input  logic                 load_AcReg,
    input  logic                 clr_AcReg,
    input  logic                 load_SaidaReg,
    input  logic                 clr_SaidaReg,
    input  logic                 Sel0,
    input  logic                 Sel1,
    output logic [WIDTH-1:0]     acumulador,
    output logic [WIDTH-1:0]     saida,
    output logic                 overflow,
    output logic                 saida_valid,
    output logic [CNT_WIDTH-1:0] op_count
);
    logic [WIDTH-1:0]     ac_q, ac_d, sa_q, sa_d;
    logic                 ovf_q, ovf_d, vld_q, vld_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]       sum, a_ext, e_ext;
    logic                 alu_ovf;
    logic [WIDTH-1:0]     alu_res;

    assign a_ext   = {ac_q[WIDTH-1], ac_q};
    assign e_ext   = {entrada[WIDTH-1], entrada};
    assign sum     = Sel0 ? a_ext - e_ext : a_ext + e_ext;
    // sign-extended result disagreeing with its truncated sign bit means it left the signed range
    assign alu_ovf = sum[WIDTH] ^ sum[WIDTH-1];
`ifdef SATURATE_EN
    assign alu_res = !alu_ovf ? sum[WIDTH-1:0] :
                     sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign alu_res = sum[WIDTH-1:0];
`endif

    always_comb begin
        ac_d  = ac_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (clr_AcReg) begin
            ac_d  = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end else if (load_AcReg) begin
            ac_d  = alu_res;
            ovf_d = ovf_q | alu_ovf;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        end
        // mux reads the pre-update accumulator: no bypass
        sa_d  = clr_SaidaReg ? '0 : load_SaidaReg ? (Sel1 ? entrada : ac_q) : sa_q;
        vld_d = load_SaidaReg & ~clr_SaidaReg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ac_q  <= '0;
            sa_q  <= '0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ac_q  <= ac_d;
            sa_q  <= sa_d;
            ovf_q <= ovf_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign acumulador  = ac_q;
    assign saida       = sa_q;
    assign overflow    = ovf_q;
    assign saida_valid = vld_q;
    assign op_count    = cnt_q;
endmodule

// File: tb/tb_calculadora_datapath.sv
// tb_calculadora_datapath: random and directed stimulus against an integer reference model,
// with a per-cycle snapshot scoreboard and a saida queue drained on saida_valid.
module tb_calculadora_datapath;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] entrada = '0;
    logic       load_AcReg = 0, clr_AcReg = 0, load_SaidaReg = 0, clr_SaidaReg = 0, Sel0 = 0, Sel1 = 0;
    logic [7:0] acumulador, saida, op_count;
    logic       overflow, saida_valid;

    calculadora_datapath #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .entrada(entrada),
        .load_AcReg(load_AcReg), .clr_AcReg(clr_AcReg),
        .load_SaidaReg(load_SaidaReg), .clr_SaidaReg(clr_SaidaReg),
        .Sel0(Sel0), .Sel1(Sel1),
        .acumulador(acumulador), .saida(saida), .overflow(overflow),
        .saida_valid(saida_valid), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {int acc; int sai; int ovf; int cnt; int vld;} snap_t;
    snap_t q[$];
    int    sq[$];
    int    checks = 0, errors = 0;
    int    m_acc = 0, m_sai = 0, m_ovf = 0, m_cnt = 0, m_vld = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && q.size() > 0) begin
            snap_t s;
            s = q.pop_front();
            chk("acumulador", int'($signed(acumulador)), s.acc);
            chk("saida", int'($signed(saida)), s.sai);
            chk("overflow", int'(overflow), s.ovf);
            chk("op_count", int'(op_count), s.cnt);
            chk("saida_valid", int'(saida_valid), s.vld);
        end
        if (!reset && saida_valid) begin
            if (sq.size() == 0) chk("spurious_valid", 1, 0);
            else chk("valid_saida", int'($signed(saida)), sq.pop_front());
        end
    end

    task automatic model(input int e);
        int old_acc, r;
        old_acc = m_acc;
        if (clr_AcReg) begin
            m_acc = 0; m_ovf = 0; m_cnt = 0;
        end else if (load_AcReg) begin
            r = Sel0 ? m_acc - e : m_acc + e;
            if (r > 127 || r < -128) m_ovf = 1;
`ifdef SATURATE_EN
            m_acc = r > 127 ? 127 : r < -128 ? -128 : r;
`else
            m_acc = ((r + 128 + 256) % 256) - 128;
`endif
            if (m_cnt < 255) m_cnt++;
        end
        m_sai = clr_SaidaReg ? 0 : load_SaidaReg ? (Sel1 ? e : old_acc) : m_sai;
        m_vld = (load_SaidaReg && !clr_SaidaReg) ? 1 : 0;
    endtask

    task automatic cyc(input logic la, ca, ls, cs, s0, s1, input int e);
        load_AcReg = la; clr_AcReg = ca; load_SaidaReg = ls; clr_SaidaReg = cs;
        Sel0 = s0; Sel1 = s1; entrada = 8'(e);
        @(posedge clk);
        model(int'($signed(8'(e))));
        q.push_back('{m_acc, m_sai, m_ovf, m_cnt, m_vld});
        if (m_vld == 1) sq.push_back(m_sai);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_acc"}, int'(acumulador), 0);
        chk({tag, "_sai"}, int'(saida), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_vld"}, int'(saida_valid), 0);
        chk({tag, "_cnt"}, int'(op_count), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        zero_chk("reset");
        reset = 1'b0;
        idle();
        // reset mid-operation
        cyc(1, 0, 0, 0, 0, 0, 5);
        load_AcReg = 1; entrada = 8'd5;
        #2 reset = 1'b1;
        #1 zero_chk("async_rst");
        q.delete(); sq.delete();
        m_acc = 0; m_sai = 0; m_ovf = 0; m_cnt = 0; m_vld = 0;
        @(posedge clk); #1 zero_chk("rst_hold");
        @(negedge clk); reset = 1'b0;
        idle();
        // show input
        cyc(0, 0, 1, 0, 0, 1, 8'h2A);
        idle();
        // add/subtract chain
        cyc(1, 0, 0, 0, 0, 0, 10);
        cyc(1, 0, 0, 1, 1, 0, 3);
        cyc(0, 0, 1, 0, 0, 0, 0);
        idle();
        // overflow and sticky flag
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 100);
        cyc(1, 0, 0, 0, 0, 0, 50);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        // priority and read-before-write
        cyc(1, 0, 0, 0, 0, 0, 7);
        cyc(1, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 0, 1, 55);
        idle();
        // counter saturation
        cyc(0, 1, 0, 0, 0, 0, 0);
        repeat (260) cyc(1, 0, 0, 0, $urandom_range(0, 1), 0, $urandom_range(0, 255));
        idle();
        // random traffic
        repeat (400) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                         $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255));
        idle();
        #1;
        chk("queue_drained", q.size() + sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/calculadora_datapath.md
Name: calculadora_datapath

Overview:
- Datapath stage directly downstream of the calculator's Mealy control FSM. Consumes its six control strobes and performs the register updates.
- Holds the accumulator register (AcReg) and the displayed output register (SaidaReg), plus a signed add/subtract unit and the output select mux.
- Adds overflow tracking, an output-valid strobe and an operation counter for the display and status logic.

Parameters:
- WIDTH, 8, data width of entrada, AcReg and SaidaReg; signed two's complement.
- CNT_WIDTH, 8, width of the accumulate-operation counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- entrada  input  WIDTH  operand and input value, signed
- load_AcReg  input  1  write ALU result into AcReg
- clr_AcReg  input  1  clear AcReg, overflow and op_count
- load_SaidaReg  input  1  write mux result into SaidaReg
- clr_SaidaReg  input  1  clear SaidaReg
- Sel0  input  1  ALU op: 0 = AcReg + entrada, 1 = AcReg - entrada
- Sel1  input  1  output mux: 1 = entrada, 0 = AcReg
- acumulador  output  WIDTH  current AcReg value
- saida  output  WIDTH  current SaidaReg value
- overflow  output  1  sticky signed-overflow flag
- saida_valid  output  1  one-cycle pulse after SaidaReg is written by a load
- op_count  output  CNT_WIDTH  number of accumulate operations since the last clear

Behaviour:
- Reset (async, active-high): acumulador=0, saida=0, overflow=0, saida_valid=0, op_count=0. Takes effect immediately and discards any operation in flight.
- ALU is combinational. It computes AcReg ± entrada at WIDTH+1 bits. Signed overflow is set when both operands of the effective addition share a sign and the result sign differs.
- AcReg update on the clock edge, by priority:
  - clr_AcReg wins: AcReg=0, overflow=0, op_count=0.
  - Otherwise, if load_AcReg: AcReg=ALU result truncated to WIDTH bits (wrap-around). overflow |= ALU overflow. op_count increments and saturates at all-ones, with no wrap.
- SaidaReg update on the clock edge, by priority:
  - clr_SaidaReg wins: SaidaReg=0, and saida_valid is not pulsed.
  - Otherwise, if load_SaidaReg: SaidaReg = Sel1 ? entrada : AcReg.
- saida_valid: registered. It is 1 in the cycle following an edge where load_SaidaReg=1 and clr_SaidaReg=0; otherwise 0.
- Simultaneous load_AcReg and load_SaidaReg with Sel1=0: SaidaReg captures the pre-update AcReg value. This is one-cycle read-before-write; there is no bypass.
- Sel0 is ignored when load_AcReg=0. Sel1 is ignored when load_SaidaReg=0.
- All strobes idle (all 0): every register holds its value and saida_valid=0.
- Latency: an operation strobed at edge N is visible on acumulador/saida after edge N; saida_valid is high during cycle N+1.
- Strobes are sampled every cycle. Holding load_AcReg high for k cycles performs k accumulations; the FSM's repeated codes rely on this.

Optional Feature:
- Macro SATURATE_EN.
- Defined: on overflow in a load_AcReg cycle, AcReg clamps to the signed maximum (positive overflow, e.g. 127 at WIDTH=8) or the signed minimum (negative overflow, -128). overflow is still set and sticky.
- Undefined: the result wraps modulo 2^WIDTH as specified above.

Test Plan:
- Reset mid-operation: load_AcReg=1 with entrada=5, then assert reset between edges -> all outputs 0 immediately, and stay 0 until the first strobe after release.
- Show input: Sel1=1, load_SaidaReg=1, entrada=8'h2A for one cycle -> saida=0x2A after the edge; saida_valid=1 for exactly the next cycle; acumulador=0.
- Add/subtract chain (WIDTH=8):
  - Add 10 -> AcReg=10.
  - Subtract 3 (Sel0=1), each with clr_SaidaReg=1 -> AcReg=7, saida=0, op_count=2, saida_valid never pulses.
  - Then Sel1=0, load_SaidaReg=1 -> saida=7.
- Overflow: AcReg=100, add 50 -> acumulador=-106 (0x96) without SATURATE_EN, or 127 with SATURATE_EN; overflow=1 in both builds. A following add of 1 keeps overflow=1. clr_AcReg -> AcReg=0, overflow=0, op_count=0.
- Priority and read-before-write: AcReg=7, same cycle load_AcReg (add 1) + load_SaidaReg (Sel1=0) -> saida=7, acumulador=8. Same cycle clr_SaidaReg + load_SaidaReg -> saida=0, no saida_valid.
- Counter saturation: CNT_WIDTH=8, 260 consecutive load_AcReg cycles -> op_count=255, and it holds there.
